// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per cycle, LSB first.
// Subtraction feeds ~B with an inverted carry-in, so cin behaves as a borrow-in.
module add_sub_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    count_q, count_d;

  logic [DIGIT:0]   sum;
  logic             c_top;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    count_d = count_q;

    sum   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of this digit, recovered from the sum bit and its operands.
    c_top = sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_ADD;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          count_d = '0;
          out_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_ADD: begin
        // Concatenate-then-shift keeps the DIGIT == WIDTH case free of empty slices.
        out_d   = WIDTH'({sum[DIGIT-1:0], out_q} >> DIGIT);
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = sum[DIGIT];
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          state_d = S_DONE;
          cout_d  = sum[DIGIT];
          ovf_d   = c_top ^ sum[DIGIT];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign busy = (state_q == S_ADD);
  assign done = (state_q == S_DONE);
  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
